vga_cursor_cmd_ctrl: RTL and testbench
======================================

Name: vga_cursor_cmd_ctrl

Overview:
- Sequences the VGA box-position datapath from a single UART byte stream. Parses ASCII commands, stages new X/Y cell coordinates, and commits them only at frame boundaries so the box never tears mid-frame.
- Sits between a UART receiver (byte + valid strobe) and the VGA renderer, which draws a 40x30-pixel cell at position_x*40, position_y*30.

Parameters:
- TIMEOUT_CYC, 1_000_000, clk cycles allowed between bytes of one command before abort (10 ms at 100 MHz).
- MAX_X, 15, largest legal X cell index (640/40 - 1).
- MAX_Y, 15, largest legal Y cell index (480/30 - 1).

Ports:
- clk  input  1  system clock, 100 MHz.
- reset_p  input  1  asynchronous, active-high reset.
- rx_data  input  8  received byte; valid only when rx_valid=1.
- rx_valid  input  1  one-cycle strobe per received byte.
- frame_start  input  1  one-cycle strobe at start of vertical blanking.
- position_x  output  8  committed X cell index to renderer.
- position_y  output  8  committed Y cell index to renderer.
- busy  output  1  high while a command is partially received.
- pending  output  1  high while any staged value awaits commit.
- cmd_err  output  1  one-cycle pulse on a rejected or aborted command.

Behaviour:
- Reset (async, reset_p=1): position_x=0, position_y=0, shadows=0, pend_x=pend_y=0, state=IDLE, busy=0, pending=0, cmd_err=0, timeout counter=0.
- Command grammar, case-insensitive:
  - 'X' h h TERM sets X.
  - 'Y' h h TERM sets Y.
  - 'R' TERM sets both X and Y to 0.
  - h = '0'-'9', 'A'-'F', 'a'-'f'. TERM = 0x0D or 0x0A.
- FSM states: IDLE, GET_HI, GET_LO, WAIT_TERM. All transitions occur only on rx_valid=1 (except timeout).
  - IDLE: 'X'/'Y' latches axis select and goes to GET_HI. 'R' marks reset-command and goes to WAIT_TERM. TERM is ignored silently (stays IDLE). Any other byte pulses cmd_err.
  - GET_HI: a hex digit latches the high nibble and goes to GET_LO; a non-hex byte is an error.
  - GET_LO: a hex digit latches the low nibble and goes to WAIT_TERM; a non-hex byte is an error.
  - WAIT_TERM: TERM validates and stages, then returns to IDLE. Any other byte is an error.
- Validation at TERM: the 8-bit value must be <= MAX_X (or MAX_Y for Y).
  - Out of range: error; shadows and pending flags unchanged.
  - In range: write the shadow for that axis and set its pend flag. 'R' writes both shadows to 0 and sets both pend flags.
- Error handling: cmd_err=1 for exactly the cycle after the offending byte; state returns to IDLE; the partial command is discarded. Previously staged values are not affected.
- Timeout: the counter clears on every accepted byte and on entering IDLE, and increments while state != IDLE. When it reaches TIMEOUT_CYC, the FSM goes to IDLE and pulses cmd_err (same single-pulse rule).
- Commit: on frame_start=1, every axis with its pend flag set copies shadow to output and clears the flag. Outputs update on the clock edge that samples frame_start (visible the next cycle). An axis with no pending value keeps its old output.
- Overwrite: a second valid command for the same axis before commit replaces the shadow; only the latest value is committed.
- Simultaneous events:
  - Staging TERM and frame_start in the same cycle: frame_start commits only flags set before that cycle. The new value commits at the next frame_start.
  - Error and frame_start in the same cycle: the commit proceeds normally.
- Output signals: busy = (state != IDLE), combinational from the state register. pending = pend_x | pend_y.
- Reset mid-command or mid-pending: everything returns to reset values immediately; no commit occurs.
- Width rules: the value is {hi_nibble, lo_nibble}, 8 bits unsigned; range compares are unsigned.

Test Plan:
- Bytes "X0A\r", then frame_start -> pending=1 after TERM; position_x stays 0 until frame_start; then position_x=0x0A, pending=0, position_y=0.
- Bytes "y0f\n" then "X03\r", no frame_start yet, then one frame_start -> both axes commit together: position_x=3, position_y=15; cmd_err never asserted.
- Bytes "X10\r" (16 > MAX_X) -> cmd_err single pulse after '\r'; position_x and pending unchanged; FSM in IDLE (busy=0).
- Bytes "X0" then silence for TIMEOUT_CYC cycles -> cmd_err pulse, busy falls to 0; a following "X05\r" plus frame_start gives position_x=5.
- "X07\r" with TERM strobe in the same cycle as frame_start -> position_x unchanged that frame; position_x=7 after the next frame_start.
- After committing (5,9), send "R\r", then assert reset_p mid-"Y0" -> reset drives position_x=position_y=0, busy=0, pending=0 immediately; no spurious cmd_err.

Source files
------------

// File: rtl/vga_cursor_cmd_ctrl_if.sv
// Byte-stream command port and committed cursor position for the VGA box controller.
// rx_valid qualifies rx_data for exactly one cycle; there is no ready, every strobed byte is consumed.
interface vga_cursor_cmd_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_start;
  logic [7:0] position_x;
  logic [7:0] position_y;
  logic       busy;
  logic       pending;
  logic       cmd_err;
  logic [1:0] state_dbg;

  modport master (
    output rx_data, rx_valid, frame_start,
    input  position_x, position_y, busy, pending, cmd_err, state_dbg
  );

  modport slave (
    input  rx_data, rx_valid, frame_start,
    output position_x, position_y, busy, pending, cmd_err, state_dbg
  );
endinterface

// File: rtl/vga_cursor_cmd_ctrl.sv
// Parses ASCII X/Y/R cursor commands from a UART byte stream, stages the cell
// coordinates and commits them to the renderer only on frame_start.
module vga_cursor_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned MAX_X       = 15,
  parameter int unsigned MAX_Y       = 15
) (
  input logic                 clk,
  input logic                 reset_p,
  vga_cursor_cmd_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] MAX_X_B = 8'(MAX_X);
  localparam logic [7:0] MAX_Y_B = 8'(MAX_Y);
  localparam logic [7:0] CH_X = 8'h58;
  localparam logic [7:0] CH_Y = 8'h59;
  localparam logic [7:0] CH_R = 8'h52;

  typedef enum logic [1:0] {IDLE, GET_HI, GET_LO, WAIT_TERM} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          axis_y_q, r_cmd_q;
  logic [3:0]    hi_q, lo_q;
  logic [7:0]    shadow_x_q, shadow_y_q;
  logic          pend_x_q, pend_y_q;
  logic [7:0]    pos_x_q, pos_y_q;
  logic          err_q;

  logic       err_d, latch_axis, latch_r, latch_hi, latch_lo, stage_x, stage_y;
  logic [7:0] stage_val;

  function automatic logic [7:0] to_upper(input logic [7:0] b);
    return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
  endfunction

  function automatic logic is_hex(input logic [7:0] u);
    return (u >= 8'h30 && u <= 8'h39) || (u >= 8'h41 && u <= 8'h46);
  endfunction

  function automatic logic [3:0] hex_val(input logic [7:0] u);
    logic [7:0] t;
    t = (u <= 8'h39) ? u - 8'h30 : u - 8'h37;
    return t[3:0];
  endfunction

  logic [7:0] rx_u;
  logic       rx_hex, rx_term, timeout_hit;
  logic [7:0] term_val;

  assign rx_u        = to_upper(bus.rx_data);
  assign rx_hex      = is_hex(rx_u);
  assign rx_term     = (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);
  assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYC));
  assign term_val    = {hi_q, lo_q};

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    err_d      = 1'b0;
    latch_axis = 1'b0;
    latch_r    = 1'b0;
    latch_hi   = 1'b0;
    latch_lo   = 1'b0;
    stage_x    = 1'b0;
    stage_y    = 1'b0;
    stage_val  = 8'h00;
    if (bus.rx_valid) begin
      case (state_q)
        IDLE: begin
          if (rx_u == CH_X || rx_u == CH_Y) begin
            latch_axis = 1'b1;
            state_d    = GET_HI;
          end else if (rx_u == CH_R) begin
            latch_r = 1'b1;
            state_d = WAIT_TERM;
          end else if (!rx_term) begin
            err_d = 1'b1;
          end
        end
        GET_HI: begin
          if (rx_hex) begin
            latch_hi = 1'b1;
            state_d  = GET_LO;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        GET_LO: begin
          if (rx_hex) begin
            latch_lo = 1'b1;
            state_d  = WAIT_TERM;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        WAIT_TERM: begin
          state_d = IDLE;
          if (!rx_term) begin
            err_d = 1'b1;
          end else if (r_cmd_q) begin
            stage_x = 1'b1;
            stage_y = 1'b1;
          end else if (axis_y_q) begin
            if (term_val <= MAX_Y_B) begin
              stage_y   = 1'b1;
              stage_val = term_val;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            if (term_val <= MAX_X_B) begin
              stage_x   = 1'b1;
              stage_val = term_val;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && timeout_hit) begin
      // A byte arriving on the expiry cycle still counts; only silence aborts.
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      cnt_q      <= '0;
      axis_y_q   <= 1'b0;
      r_cmd_q    <= 1'b0;
      hi_q       <= 4'h0;
      lo_q       <= 4'h0;
      shadow_x_q <= 8'h00;
      shadow_y_q <= 8'h00;
      pend_x_q   <= 1'b0;
      pend_y_q   <= 1'b0;
      pos_x_q    <= 8'h00;
      pos_y_q    <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      err_q <= err_d;
      if (state_d == IDLE || bus.rx_valid) cnt_q <= '0;
      else                                 cnt_q <= cnt_q + CW'(1);
      if (latch_axis) begin
        axis_y_q <= (rx_u == CH_Y);
        r_cmd_q  <= 1'b0;
      end
      if (latch_r)  r_cmd_q <= 1'b1;
      if (latch_hi) hi_q    <= hex_val(rx_u);
      if (latch_lo) lo_q    <= hex_val(rx_u);
      // Commit reads the flags and shadows as they were before this edge;
      // a value staged on the same edge waits for the next frame.
      if (bus.frame_start) begin
        if (pend_x_q) begin
          pos_x_q  <= shadow_x_q;
          pend_x_q <= 1'b0;
        end
        if (pend_y_q) begin
          pos_y_q  <= shadow_y_q;
          pend_y_q <= 1'b0;
        end
      end
      if (stage_x) begin
        shadow_x_q <= stage_val;
        pend_x_q   <= 1'b1;
      end
      if (stage_y) begin
        shadow_y_q <= stage_val;
        pend_y_q   <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.busy       = (state_q != IDLE);
    bus.pending    = pend_x_q | pend_y_q;
    bus.cmd_err    = err_q;
    bus.position_x = pos_x_q;
    bus.position_y = pos_y_q;
    bus.state_dbg  = state_q;
  end

endmodule

// File: tb/tb_vga_cursor_cmd_ctrl.sv
// Randomized bench for vga_cursor_cmd_ctrl: a grammar-level command model predicts
// the observable outputs each cycle and a negedge monitor compares them.
module tb_vga_cursor_cmd_ctrl;
  localparam int T     = 40;
  localparam int MAX_X = 15;
  localparam int MAX_Y = 15;
  localparam int W     = 19;

  logic clk;
  logic reset_p;
  vga_cursor_cmd_ctrl_if bus();

  vga_cursor_cmd_ctrl #(.TIMEOUT_CYC(T), .MAX_X(MAX_X), .MAX_Y(MAX_Y)) dut (
    .clk(clk),
    .reset_p(reset_p),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: the partial command is kept as the list of bytes seen so far.
  logic [7:0] m_buf[$];
  int         m_cyc = 0;
  int         m_e0  = 0;
  logic [7:0] m_sh_x, m_sh_y, m_pos_x, m_pos_y;
  bit         m_px, m_py, m_err;
  bit         rand_fs = 0;

  task automatic model_reset();
    m_buf.delete();
    m_sh_x = 0; m_sh_y = 0; m_pos_x = 0; m_pos_y = 0;
    m_px = 0; m_py = 0; m_err = 0;
  endtask

  function automatic bit is_hex(input logic [7:0] u);
    return (u >= "0" && u <= "9") || (u >= "A" && u <= "F");
  endfunction

  function automatic int hexv(input logic [7:0] u);
    return (u <= "9") ? int'(u) - 48 : int'(u) - 55;
  endfunction

  task automatic model_byte(input logic [7:0] d);
    logic [7:0] u;
    bit term;
    int val;
    u    = (d >= "a" && d <= "z") ? d - 8'd32 : d;
    term = (d == 8'h0d || d == 8'h0a);
    if (m_buf.size() == 0) begin
      if (u == "X" || u == "Y" || u == "R") m_buf.push_back(u);
      else if (!term) m_err = 1;
    end else if (m_buf[0] == "R") begin
      if (term) begin
        m_sh_x = 0; m_sh_y = 0; m_px = 1; m_py = 1;
      end else m_err = 1;
      m_buf.delete();
    end else if (m_buf.size() < 3) begin
      if (is_hex(u)) m_buf.push_back(u);
      else begin m_err = 1; m_buf.delete(); end
    end else begin
      if (!term) m_err = 1;
      else begin
        val = hexv(m_buf[1]) * 16 + hexv(m_buf[2]);
        if (m_buf[0] == "X") begin
          if (val > MAX_X) m_err = 1;
          else begin m_sh_x = 8'(val); m_px = 1; end
        end else begin
          if (val > MAX_Y) m_err = 1;
          else begin m_sh_y = 8'(val); m_py = 1; end
        end
      end
      m_buf.delete();
    end
  endtask

  task automatic model_cycle(input bit v, input logic [7:0] d, input bit fs);
    m_cyc++;
    m_err = 0;
    if (fs) begin
      if (m_px) begin m_pos_x = m_sh_x; m_px = 0; end
      if (m_py) begin m_pos_y = m_sh_y; m_py = 0; end
    end
    if (v) begin
      model_byte(d);
      m_e0 = m_cyc;
    end else if (m_buf.size() != 0 && m_cyc - m_e0 == T + 1) begin
      m_buf.delete();
      m_err = 1;
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit fs);
    bit fs_eff;
    fs_eff = fs | (rand_fs && $urandom_range(0, 11) == 0);
    bus.rx_valid    = v;
    bus.rx_data     = v ? d : 8'($urandom_range(0, 255));
    bus.frame_start = fs_eff;
    model_cycle(v, d, fs_eff);
    @(posedge clk);
    exp_q.push_back({m_pos_x, m_pos_y, (m_buf.size() != 0), (m_px | m_py), m_err});
    #1;
    bus.rx_valid    = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic send_str(input string s, input bit fs_last);
    for (int i = 0; i < s.len(); i++)
      step(1'b1, s[i], fs_last && (i == s.len() - 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic frame();
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic check_reset_state(input string name);
    logic [W-1:0] act;
    act = {bus.position_x, bus.position_y, bus.busy, bus.pending, bus.cmd_err};
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL %s: actual px=%0d py=%0d busy=%0b pend=%0b err=%0b required all zero",
               name, act[18:11], act[10:3], act[2], act[1], act[0]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset_p = 1'b1;
    model_reset();
    #1 check_reset_state("async_reset");
    @(negedge clk);
    check_reset_state("reset_held");
    #2 reset_p = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [W-1:0] exp, act;
    if (!reset_p && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      act = {bus.position_x, bus.position_y, bus.busy, bus.pending, bus.cmd_err};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL cycle_obs t=%0t: actual px=%0d py=%0d busy=%0b pend=%0b err=%0b required px=%0d py=%0d busy=%0b pend=%0b err=%0b",
                 $time, act[18:11], act[10:3], act[2], act[1], act[0],
                 exp[18:11], exp[10:3], exp[2], exp[1], exp[0]);
      end
    end
  end

  function automatic logic [7:0] rand_char();
    string alpha;
    alpha = "XxYyRr0123456789aAbcfFgZ\r\n";
    if ($urandom_range(0, 9) == 0) return 8'($urandom_range(0, 255));
    return alpha[$urandom_range(0, alpha.len() - 1)];
  endfunction

  task automatic rand_cmd();
    string s;
    string ax;
    int val;
    int pick;
    pick = $urandom_range(0, 5);
    val  = $urandom_range(0, 20);
    case (pick)
      0: ax = "X";
      1: ax = "x";
      2: ax = "Y";
      3: ax = "y";
      default: ax = "R";
    endcase
    if (ax == "R") s = ($urandom_range(0, 1) != 0) ? "R\r" : "r\n";
    else if ($urandom_range(0, 1) != 0) s = $sformatf("%s%02x\r", ax, val);
    else s = $sformatf("%s%02X\n", ax, val);
    send_str(s, 1'b0);
  endtask

  initial begin
    reset_p         = 1'b1;
    bus.rx_valid    = 1'b0;
    bus.rx_data     = 8'h00;
    bus.frame_start = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state("power_on_reset");
    #2 reset_p = 1'b0;

    // Basic stage then commit.
    send_str("X0A\r", 1'b0); idle(3); frame(); idle(2);
    // Two axes staged, committed together.
    send_str("y0f\n", 1'b0); send_str("X03\r", 1'b0); idle(2); frame(); idle(2);
    // Out of range value.
    send_str("X10\r", 1'b0); idle(2);
    // Timeout mid-command, then recovery.
    send_str("X0", 1'b0); idle(T + 5); send_str("X05\r", 1'b0); frame(); idle(2);
    // TERM coincident with frame_start.
    send_str("X07\r", 1'b1); idle(2); frame(); idle(2);
    // Malformed commands.
    send_str("Q", 1'b0); send_str("XG", 1'b0); send_str("X1Z", 1'b0);
    send_str("X12Q", 1'b0); send_str("R5", 1'b0); send_str("\r\n", 1'b0); idle(2);
    // Overwrite before commit, then reset command, then reset mid-command.
    send_str("X05\r", 1'b0); send_str("Y02\r", 1'b0); send_str("Y09\r", 1'b0);
    frame(); idle(2);
    send_str("R\r", 1'b0); idle(1);
    send_str("Y0", 1'b0);
    do_reset();
    idle(3);

    // Randomized traffic with random frame strobes.
    rand_fs = 1;
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: rand_cmd();
        5, 6:          step(1'b1, rand_char(), 1'b0);
        7:             frame();
        8:             idle($urandom_range(1, 4));
        default:       idle($urandom_range(T - 2, T + 3));
      endcase
    end
    rand_fs = 0;
    idle(3);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
